// File: rtl/tb_dir_packer.sv
// Traceback direction packer.
//
// Receives the 2-bit direction stream from the GACT traceback unit, packs the
// non-zero directions LSB-first into words of DIR_PER_WORD directions, and
// hands the words to the result writer through a small first-word-fall-through
// FIFO. Each tile ends with a word tagged out_last. That word is either the
// partial word, or an empty terminator, or the full word whose last direction
// arrived together with tb_done.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              arm for a new traceback (honoured only when idle)
//   dir_in, dir_valid  direction stream (0=ZERO, 1=V, 2=H, 3=M)
//   tb_done            single-cycle end-of-traceback strobe
//   out_data           packed word, first direction in bits [1:0]
//   out_count          number of valid directions in out_data
//   out_last           final word of the tile
//   out_valid          output word valid
//   out_ready          consumer accepts the word
//   num_dirs           directions accepted since start
//   overflow           sticky: a full word was dropped on a full FIFO
//   busy               not idle
//   complete           one-cycle pulse when the tile has fully drained
module tb_dir_packer #(
  parameter int unsigned DIR_PER_WORD   = 16,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned LOG_FIFO_DEPTH = 2,
  parameter int unsigned ADDR_WIDTH     = 20,
  parameter int unsigned LOG_NUM_PE     = 6
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [1:0]                          dir_in,
  input  logic                                dir_valid,
  input  logic                                tb_done,
  output logic [2*DIR_PER_WORD-1:0]           out_data,
  output logic [$clog2(DIR_PER_WORD):0]       out_count,
  output logic                                out_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ADDR_WIDTH+LOG_NUM_PE-1:0]    num_dirs,
  output logic                                overflow,
  output logic                                busy,
  output logic                                complete
);

  localparam int unsigned DataW = 2 * DIR_PER_WORD;
  localparam int unsigned CntW  = $clog2(DIR_PER_WORD) + 1;
  localparam int unsigned NumW  = ADDR_WIDTH + LOG_NUM_PE;
  localparam int unsigned EntW  = DataW + CntW + 1;

  typedef enum logic [1:0] {StIdle, StPack, StFlush, StDrain} state_e;

  state_e            state_q, state_d;
  logic [DataW-1:0]  shift_q, shift_d;
  logic [CntW-1:0]   fill_q, fill_d;
  logic [NumW-1:0]   num_q, num_d;
  logic              ovf_q, ovf_d;

  // FIFO storage; pointers carry one extra wrap bit to tell full from empty.
  logic [EntW-1:0]         mem_q [FIFO_DEPTH];
  logic [LOG_FIFO_DEPTH:0] wr_ptr_q, rd_ptr_q;
  logic                    fifo_empty, fifo_full, pop, can_push;
  logic                    push;
  logic [DataW-1:0]        push_data;
  logic [CntW-1:0]         push_cnt;
  logic                    push_last;
  logic [EntW-1:0]         rd_entry;

  logic              accept, word_done;
  logic [DataW-1:0]  ins_word;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[LOG_FIFO_DEPTH] != rd_ptr_q[LOG_FIFO_DEPTH]) &&
                      (wr_ptr_q[LOG_FIFO_DEPTH-1:0] == rd_ptr_q[LOG_FIFO_DEPTH-1:0]);
  assign pop        = !fifo_empty && out_ready;
  // A full FIFO still takes a push when a word leaves in the same cycle.
  assign can_push   = !fifo_full || pop;

  // ZERO directions carry no information and take no slot.
  assign accept    = dir_valid && (dir_in != 2'd0);
  assign ins_word  = shift_q | (DataW'(dir_in) << {fill_q, 1'b0});
  assign word_done = (fill_q == CntW'(DIR_PER_WORD - 1));

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    fill_d    = fill_q;
    num_d     = num_q;
    ovf_d     = ovf_q;
    push      = 1'b0;
    push_data = shift_q;
    push_cnt  = fill_q;
    push_last = 1'b0;
    complete  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StPack;
          shift_d = '0;
          fill_d  = '0;
          num_d   = '0;
          ovf_d   = 1'b0;
        end
      end

      StPack: begin
        if (accept) begin
          num_d = num_q + 1'b1;
          if (word_done) begin
            if (tb_done && !can_push) begin
              // The last word may never be dropped: park it and let FLUSH
              // retry it with its full count.
              shift_d = ins_word;
              fill_d  = CntW'(DIR_PER_WORD);
              state_d = StFlush;
            end else begin
              push      = can_push;
              push_data = ins_word;
              push_cnt  = CntW'(DIR_PER_WORD);
              push_last = tb_done;
              ovf_d     = ovf_q | !can_push;
              shift_d   = '0;
              fill_d    = '0;
              if (tb_done) begin
                state_d = StDrain;
              end
            end
          end else begin
            shift_d = ins_word;
            fill_d  = fill_q + 1'b1;
            if (tb_done) begin
              state_d = StFlush;
            end
          end
        end else if (tb_done) begin
          state_d = StFlush;
        end
      end

      StFlush: begin
        push_last = 1'b1;
        if (can_push) begin
          push    = 1'b1;
          shift_d = '0;
          fill_d  = '0;
          state_d = StDrain;
        end
      end

      StDrain: begin
        if (fifo_empty) begin
          complete = 1'b1;
          state_d  = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      fill_q  <= '0;
      num_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      fill_q  <= fill_d;
      num_q   <= num_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[LOG_FIFO_DEPTH-1:0]] <= {push_data, push_cnt, push_last};
    end
  end

  assign rd_entry  = mem_q[rd_ptr_q[LOG_FIFO_DEPTH-1:0]];
  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? rd_entry[EntW-1 -: DataW] : '0;
  assign out_count = out_valid ? rd_entry[CntW:1] : '0;
  assign out_last  = out_valid ? rd_entry[0] : 1'b0;

  assign num_dirs  = num_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_tb_dir_packer.sv
module tb_tb_dir_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  dir_in = 2'd0;
  logic        dir_valid = 1'b0;
  logic        tb_done = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_count;
  logic        out_last;
  logic        out_valid;
  logic [25:0] num_dirs;
  logic        overflow;
  logic        busy;
  logic        complete;

  tb_dir_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dir_in    (dir_in),
    .dir_valid (dir_valid),
    .tb_done   (tb_done),
    .out_data  (out_data),
    .out_count (out_count),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .num_dirs  (num_dirs),
    .overflow  (overflow),
    .busy      (busy),
    .complete  (complete)
  );

  always #5 clk = ~clk;

  typedef logic [37:0] word_t;  // {data, count, last}
  typedef struct packed {
    logic       v;
    logic [1:0] d;
  } stim_t;
  typedef struct {
    string       name;
    int unsigned len;
    logic [39:0] dirs;
    logic [19:0] vld;
    logic [31:0] e_data;
    logic [4:0]  e_cnt;
    int unsigned e_num;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cmpl_cnt = 0;
  int cmpl_base;
  int got_base;
  int unsigned exp_num;
  word_t got_q[$];
  word_t exp_q[$];
  stim_t stim_q[$];
  vec_t  tbl[$];

  // Transfers happen on the next rising edge; sample half a cycle earlier.
  always @(negedge clk) begin
    if (out_valid && out_ready) got_q.push_back({out_data, out_count, out_last});
    if (complete) cmpl_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input string n, input int unsigned len, input logic [39:0] dirs,
                         input logic [19:0] vld, input logic [31:0] e_data,
                         input logic [4:0] e_cnt, input int unsigned e_num);
    vec_t v;
    v.name = n; v.len = len; v.dirs = dirs; v.vld = vld;
    v.e_data = e_data; v.e_cnt = e_cnt; v.e_num = e_num;
    tbl.push_back(v);
  endtask

  task automatic mark();
    got_base  = got_q.size();
    cmpl_base = cmpl_cnt;
  endtask

  task automatic wait_idle(input bit rnd, input string name);
    int n = 0;
    while (busy && n < 600) begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      n++;
    end
    out_ready = 1'b1;
    chk({name, "_idle"}, busy, 0);
  endtask

  // Start a tile, play stim_q (tb_done on the final element), wait for drain.
  task automatic run_tile(input bit rnd, input string name);
    mark();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < stim_q.size(); k++) begin
      dir_valid = stim_q[k].v;
      dir_in    = stim_q[k].d;
      tb_done   = (k == stim_q.size() - 1);
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    dir_valid = 1'b0;
    dir_in    = 2'd0;
    tb_done   = 1'b0;
    wait_idle(rnd, name);
  endtask

  task automatic check_words(input string name);
    chk({name, "_nwords"}, got_q.size() - got_base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (got_base + i < got_q.size())
        chk($sformatf("%s_w%0d", name, i), got_q[got_base + i], exp_q[i]);
    end
  endtask

  task automatic check_tail(input string name);
    check_words(name);
    chk({name, "_num"}, num_dirs, exp_num);
    chk({name, "_complete"}, cmpl_cnt - cmpl_base, 1);
  endtask

  // Reference: gather accepted directions, cut every 16 into a word; the tile
  // ends with a last-tagged word, which is the final full word only when its
  // closing direction came with tb_done, else the remainder (possibly empty).
  task automatic model_tile();
    int unsigned dirs[$];
    bit closing_full;
    logic [31:0] w;
    exp_q.delete();
    closing_full = 1'b0;
    foreach (stim_q[k]) if (stim_q[k].v && stim_q[k].d != 2'd0) dirs.push_back(stim_q[k].d);
    exp_num = dirs.size();
    if (stim_q[stim_q.size() - 1].v && stim_q[stim_q.size() - 1].d != 2'd0 &&
        dirs.size() > 0 && dirs.size() % 16 == 0)
      closing_full = 1'b1;
    for (int base = 0; base + 16 <= dirs.size(); base += 16) begin
      w = 0;
      for (int j = 0; j < 16; j++) w = w + (dirs[base + j] << (2 * j));
      exp_q.push_back({w, 5'd16, closing_full && (base + 16 == dirs.size())});
    end
    if (!closing_full) begin
      w = 0;
      for (int j = 0; j < dirs.size() % 16; j++)
        w = w + (dirs[dirs.size() - dirs.size() % 16 + j] << (2 * j));
      exp_q.push_back({w, 5'(dirs.size() % 16), 1'b1});
    end
  endtask

  initial begin
    stim_t s;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_count", out_count, 0);
    chk("rst_last", out_last, 0);
    chk("rst_num", num_dirs, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_complete", complete, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // Single-word tiles
    add_vec("t1_basic", 5, 40'h39F, 20'h1F, 32'h39F, 5'd5, 5);
    add_vec("t5_zeros", 5, 40'h321, 20'h1F, 32'h39, 5'd3, 3);
    add_vec("invalid_skip", 3, 40'h1E, 20'h5, 32'h6, 5'd2, 2);
    add_vec("one_dir", 1, 40'h1, 20'h1, 32'h1, 5'd1, 1);
    add_vec("empty_tile", 1, 40'h0, 20'h0, 32'h0, 5'd0, 0);
    add_vec("t3_done_with_16th", 16, 40'h7FFFFFFF, 20'hFFFF, 32'h7FFFFFFF, 5'd16, 16);
    foreach (tbl[i]) begin
      stim_q.delete();
      for (int k = 0; k < tbl[i].len; k++) begin
        s.v = tbl[i].vld[k];
        s.d = tbl[i].dirs[2*k +: 2];
        stim_q.push_back(s);
      end
      run_tile(1'b0, tbl[i].name);
      exp_q.delete();
      exp_q.push_back({tbl[i].e_data, tbl[i].e_cnt, 1'b1});
      exp_num = tbl[i].e_num;
      check_tail(tbl[i].name);
    end

    // Test 2: full word, tb_done later -> empty terminator; one-cycle latency
    mark();
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      dir_valid = 1'b1; dir_in = 2'd3;
      tick();
      if (k == 14) begin
        @(negedge clk);
        chk("t2_not_yet_valid", out_valid, 0);
      end
    end
    dir_valid = 1'b0; dir_in = 2'd0;
    @(negedge clk);
    chk("t2_latency", out_valid, 1);
    tick(); tick();
    tb_done = 1'b1; tick(); tb_done = 1'b0;
    wait_idle(1'b0, "t2");
    exp_q.delete();
    exp_q.push_back({32'hFFFFFFFF, 5'd16, 1'b0});
    exp_q.push_back({32'h0, 5'd0, 1'b1});
    exp_num = 16;
    check_tail("t2");

    // Test 4: overflow with a stalled consumer
    out_ready = 1'b0;
    mark();
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 96; k++) begin
      dir_valid = 1'b1; dir_in = 2'd2;
      tick();
    end
    dir_valid = 1'b0; dir_in = 2'd0;
    tb_done = 1'b1; tick(); tb_done = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    chk("t4_ovf", overflow, 1);
    chk("t4_stall_busy", busy, 1);
    chk("t4_valid", out_valid, 1);
    chk("t4_hold_data", out_data, 32'hAAAAAAAA);
    chk("t4_hold_count", out_count, 16);
    chk("t4_hold_last", out_last, 0);
    chk("t4_num", num_dirs, 96);
    chk("t4_no_xfer", got_q.size() - got_base, 0);
    wait_idle(1'b0, "t4");
    exp_q.delete();
    repeat (4) exp_q.push_back({32'hAAAAAAAA, 5'd16, 1'b0});
    exp_q.push_back({32'h0, 5'd0, 1'b1});
    exp_num = 96;
    check_tail("t4");
    chk("t4_ovf_sticky", overflow, 1);

    // Test 6: start while busy ignored, then async reset mid-word
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      dir_valid = 1'b1; dir_in = 2'd1;
      tick();
    end
    dir_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    @(negedge clk);
    chk("t6_start_busy_num", num_dirs, 7);
    chk("t6_start_busy_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_num", num_dirs, 0);
    chk("t6_rst_ovf", overflow, 0);
    chk("t6_rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    stim_q.delete();
    s.v = 1'b1; s.d = 2'd2;
    stim_q.push_back(s);
    run_tile(1'b0, "t6_after");
    exp_q.delete();
    exp_q.push_back({32'h2, 5'd1, 1'b1});
    exp_num = 1;
    check_tail("t6_after");

    // Randomized tiles against the reference model
    for (int t = 0; t < 25; t++) begin
      int unsigned len;
      stim_q.delete();
      if (t % 5 == 0) begin
        len = 16 * $urandom_range(1, 3);
        for (int k = 0; k < len; k++) begin
          s.v = 1'b1; s.d = 2'($urandom_range(1, 3));
          stim_q.push_back(s);
        end
      end else begin
        len = $urandom_range(1, 70);
        for (int k = 0; k < len; k++) begin
          s.v = ($urandom_range(0, 3) != 0);
          s.d = 2'($urandom_range(0, 3));
          stim_q.push_back(s);
        end
      end
      model_tile();
      run_tile(1'b1, $sformatf("rnd%0d", t));
      check_tail($sformatf("rnd%0d", t));
      chk($sformatf("rnd%0d_ovf", t), overflow, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tb_dir_packer.md
Name: tb_dir_packer

Overview:
- Sits on the output side of the GACT traceback unit and is the receiver of its direction stream.
- Takes the 2-bit traceback directions (dir, dir_valid) and the done strobe, and packs the directions LSB-first into fixed-width words.
- Buffers the packed words in a small first-word-fall-through FIFO and hands them to the result writer over a valid/ready interface.
- At the end of each tile it emits a final word tagged last, then reports the total number of directions received.

Parameters:
- DIR_PER_WORD, 16: directions per output word; output word width is 2*DIR_PER_WORD.
- FIFO_DEPTH, 4: number of output words buffered; must be a power of 2.
- LOG_FIFO_DEPTH, 2: log2(FIFO_DEPTH).
- ADDR_WIDTH, 20: traceback address width.
- LOG_NUM_PE, 6: log2 of the PE count; num_dirs width is ADDR_WIDTH+LOG_NUM_PE.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  arms the block for a new traceback; honoured only in IDLE.
- dir_in  in  2  traceback direction: 0=ZERO, 1=V, 2=H, 3=M.
- dir_valid  in  1  dir_in is valid this cycle.
- tb_done  in  1  traceback unit done strobe (single-cycle pulse).
- out_data  out  2*DIR_PER_WORD  packed word; first-received direction in bits [1:0].
- out_count  out  $clog2(DIR_PER_WORD)+1  number of valid directions in out_data (0..DIR_PER_WORD).
- out_last  out  1  marks the final word of the tile.
- out_valid  out  1  out_data, out_count and out_last are valid.
- out_ready  in  1  consumer accepts the word.
- num_dirs  out  ADDR_WIDTH+LOG_NUM_PE  count of accepted directions since start.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- busy  out  1  state != IDLE.
- complete  out  1  one-cycle pulse when the tile is fully drained.

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - out_valid=0, out_data=0, out_count=0, out_last=0.
  - num_dirs=0, overflow=0, busy=0, complete=0.
  - FIFO empty; shift register and fill count cleared.
  - Applies immediately regardless of operation in progress; any partial word is discarded.
- States: IDLE, PACK, FLUSH, DRAIN.
- IDLE:
  - On start, go to PACK and clear the shift register, fill, num_dirs and overflow.
  - dir_valid and tb_done are ignored in IDLE.
- PACK:
  - A direction is accepted when dir_valid=1 and dir_in!=0.
  - An accepted direction is written at bits [2*fill+1:2*fill]; fill and num_dirs increment.
  - dir_valid with dir_in=0 is ignored; no count change.
  - When fill reaches DIR_PER_WORD, push {word, count=DIR_PER_WORD, last=0} and reset fill to 0 and the shift register to 0.
  - If the FIFO is full at a PACK push, the word is dropped and overflow is set. num_dirs still counts the dropped directions.
  - tb_done moves the state to FLUSH.
- Same-cycle events in PACK:
  - dir_valid with tb_done: the direction is accepted first.
  - If that direction completes a word, the word is pushed with last=1 and the state goes directly to DRAIN; no terminator word is sent.
- FLUSH:
  - Push {partial word, count=fill, last=1}.
  - If fill=0, this is an empty terminator word (data 0, count 0, last 1).
  - If the FIFO is full, wait in FLUSH until space is available; the terminator word is never dropped.
  - Go to DRAIN after the push.
- DRAIN:
  - Wait until the FIFO is empty, then pulse complete for one cycle and go to IDLE.
  - num_dirs holds its value until the next start.
- Output FIFO:
  - First-word-fall-through; a pushed word appears on out_valid the cycle after the push.
  - Latency is one cycle from the completing dir_valid to out_valid when the FIFO is empty.
  - A transfer occurs when out_valid & out_ready.
  - out_data, out_count and out_last are stable while out_valid=1 and out_ready=0.
  - Push and pop in the same cycle are both honoured. A push when full is allowed only if a pop occurs in the same cycle.
- start while busy is ignored.
- At complete, num_dirs equals the traceback unit's num_tb_steps.

Test Plan:
1. start; dirs 3,3,1,2,3; tb_done; out_ready=1 -> one word: out_data=0x0000039F, out_count=5, out_last=1; num_dirs=5; complete pulses once.
2. start; 16 dirs of 3; tb_done 3 cycles later -> word 0xFFFFFFFF (count 16, last 0), then word 0x0 (count 0, last 1); num_dirs=16.
3. start; 16th dir (value 1) in the same cycle as tb_done, first 15 dirs =3 -> single word 0x7FFFFFFF, count 16, last 1; no terminator word.
4. out_ready=0; 96 dirs of value 2, then tb_done -> FIFO holds 4 words of 0xAAAAAAAA; words 5 and 6 are dropped and overflow=1; FLUSH stalls. On out_ready=1: 4 words, then the terminator (count 0, last 1); num_dirs=96.
5. dir_valid=1 with dir_in=0 interleaved among 3 valid dirs -> num_dirs=3, out_count=3; the zeros occupy no slots.
6. rst_n low mid-PACK with fill=7 -> immediately out_valid=0, num_dirs=0, overflow=0, busy=0. A later start then 1 dir + tb_done -> word count 1, last 1. A start pulse while busy has no effect.
